// File: rtl/alu_if.sv
// Operand/result bundle for the 4-bit ALU.
// The master drives the operands and mode. The slave (alu) returns the result, the flags and the 7-segment patterns.
interface alu_if;
  logic [3:0]      in1;
  logic [3:0]      in2;
  logic [3:0]      mode;
  logic [7:0]      num;
  logic            neg;
  logic            cero;
  logic            carry;
  logic            des;
  logic [1:0][6:0] out;

  modport master (
    output in1, in2, mode,
    input  num, neg, cero, carry, des, out
  );

  modport slave (
    input  in1, in2, mode,
    output num, neg, cero, carry, des, out
  );
endinterface

// File: rtl/alu.sv
// 4-bit registered ALU with flags and a two-digit hex 7-segment display of the result.
// ALU_SEG_ACTIVE_HIGH_EN: when defined, segment outputs are active-high (common cathode).
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_AND = 4'd2;
  localparam logic [3:0] MODE_MUL = 4'd3;
  localparam logic [3:0] MODE_OR  = 4'd4;
  localparam logic [3:0] MODE_XOR = 4'd5;
  localparam logic [3:0] MODE_SHL = 4'd6;
  localparam logic [3:0] MODE_SHR = 4'd7;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      4'hF: p = 7'h0E;
      default: p = 7'h7F;
    endcase
`ifdef ALU_SEG_ACTIVE_HIGH_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  logic [4:0] sum_s;
  logic [7:0] diff_s;
  logic [7:0] prod_s;
  logic [7:0] r_s;
  logic       neg_s;
  logic       cero_s;
  logic       carry_s;
  logic       des_s;

  logic [7:0] num_r;
  logic       neg_r;
  logic       cero_r;
  logic       carry_r;
  logic       des_r;

  assign sum_s  = {1'b0, bus.in1} + {1'b0, bus.in2};
  assign diff_s = {4'h0, bus.in1} - {4'h0, bus.in2};
  assign prod_s = {4'h0, bus.in1} * {4'h0, bus.in2};

  // Next-state result and flag decode
  always_comb begin
    r_s     = 8'h00;
    neg_s   = 1'b0;
    carry_s = 1'b0;
    des_s   = 1'b0;
    case (bus.mode)
      MODE_ADD: begin
        r_s     = {3'b000, sum_s};
        carry_s = sum_s[4];
        des_s   = (bus.in1[3] == bus.in2[3]) && (sum_s[3] != bus.in1[3]);
      end
      MODE_SUB: begin
        r_s     = diff_s;
        neg_s   = diff_s[7];
        carry_s = (bus.in1 < bus.in2);
        des_s   = (bus.in1[3] != bus.in2[3]) && (diff_s[3] != bus.in1[3]);
      end
      MODE_AND: r_s = {4'h0, bus.in1 & bus.in2};
      MODE_MUL: r_s = prod_s;
      MODE_OR:  r_s = {4'h0, bus.in1 | bus.in2};
      MODE_XOR: r_s = {4'h0, bus.in1 ^ bus.in2};
      MODE_SHL: r_s = {4'h0, bus.in1} << bus.in2[2:0];
      MODE_SHR: r_s = {4'h0, bus.in1} >> bus.in2[2:0];
      default:  r_s = 8'h00;
    endcase
    cero_s = (r_s == 8'h00);
  end

  // Result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_r   <= 8'h00;
      neg_r   <= 1'b0;
      cero_r  <= 1'b0;
      carry_r <= 1'b0;
      des_r   <= 1'b0;
    end else begin
      num_r   <= r_s;
      neg_r   <= neg_s;
      cero_r  <= cero_s;
      carry_r <= carry_s;
      des_r   <= des_s;
    end
  end

  assign bus.num    = num_r;
  assign bus.neg    = neg_r;
  assign bus.cero   = cero_r;
  assign bus.carry  = carry_r;
  assign bus.des    = des_r;
  assign bus.out[0] = seg7(num_r[3:0]);
  assign bus.out[1] = seg7(num_r[7:4]);

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes hand-computed expectations, a monitor pops and compares after each edge.
module tb_alu;

  logic clk;
  logic rst_n;
  alu_if bus ();

  alu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] mode;
    logic [7:0] num;
    logic       neg;
    logic       cero;
    logic       carry;
    logic       des;
    logic [6:0] o1;
    logic [6:0] o0;
  } vec_t;

  vec_t vecs [17];
  vec_t expq [$];
  int   tests  = 0;
  int   failed = 0;

  // Table patterns are written active-low; flip them for the common-cathode build.
  function automatic logic [6:0] segx(input logic [6:0] v);
`ifdef ALU_SEG_ACTIVE_HIGH_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, " num"},   bus.num, e.num);
    chk({tag, " neg"},   {7'h00, bus.neg},   {7'h00, e.neg});
    chk({tag, " cero"},  {7'h00, bus.cero},  {7'h00, e.cero});
    chk({tag, " carry"}, {7'h00, bus.carry}, {7'h00, e.carry});
    chk({tag, " des"},   {7'h00, bus.des},   {7'h00, e.des});
    chk({tag, " out1"},  {1'b0, bus.out[1]}, {1'b0, segx(e.o1)});
    chk({tag, " out0"},  {1'b0, bus.out[0]}, {1'b0, segx(e.o0)});
  endtask

  // Monitor: one expectation per rising edge while any are pending
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk_all($sformatf("m%0d_%0d_%0d", e.mode, e.in1, e.in2), e);
      end
    end
  end

  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.in1  = v.in1;
    bus.in2  = v.in2;
    bus.mode = v.mode;
    expq.push_back(v);
  endtask

  initial begin
    vec_t rv;
    int   budget;
    //          in1    in2    mode   num    neg   cero  carry des   o1     o0
    vecs[0]  = '{4'd4,  4'd5,  4'd0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 7'h40, 7'h10};
    vecs[1]  = '{4'd15, 4'd15, 4'd0, 8'h1E, 1'b0, 1'b0, 1'b1, 1'b0, 7'h79, 7'h06};
    vecs[2]  = '{4'd0,  4'd10, 4'd1, 8'hF6, 1'b1, 1'b0, 1'b1, 1'b0, 7'h0E, 7'h02};
    vecs[3]  = '{4'd15, 4'd9,  4'd1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 7'h40, 7'h02};
    vecs[4]  = '{4'd15, 4'd0,  4'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h40, 7'h40};
    vecs[5]  = '{4'd12, 4'd4,  4'd2, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 7'h40, 7'h19};
    vecs[6]  = '{4'd10, 4'd5,  4'd4, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 7'h40, 7'h0E};
    vecs[7]  = '{4'd0,  4'd0,  4'd4, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h40, 7'h40};
    vecs[8]  = '{4'd15, 4'd15, 4'd3, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h06, 7'h79};
    vecs[9]  = '{4'd7,  4'd3,  4'd9, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h40, 7'h40};
    vecs[10] = '{4'd12, 4'd10, 4'd5, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 7'h40, 7'h02};
    vecs[11] = '{4'd3,  4'd5,  4'd6, 8'h60, 1'b0, 1'b0, 1'b0, 1'b0, 7'h02, 7'h40};
    vecs[12] = '{4'd12, 4'd10, 4'd7, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 7'h40, 7'h30};
    vecs[13] = '{4'd8,  4'd1,  4'd1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 7'h40, 7'h78};
    vecs[14] = '{4'd8,  4'd8,  4'd0, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 7'h79, 7'h40};
    vecs[15] = '{4'd15, 4'd12, 4'd6, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0E, 7'h40};
    vecs[16] = '{4'd9,  4'd9,  4'd15, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 7'h40, 7'h40};

    rv = '{4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 7'h40, 7'h40};

    rst_n    = 1'b0;
    bus.in1  = 4'd0;
    bus.in2  = 4'd0;
    bus.mode = 4'd0;
    #23;
    chk_all("reset_init", rv);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    budget = 0;
    while (expq.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_timeout", {7'h00, (expq.size() > 0)}, 8'h00);

    // Asynchronous reset in the middle of a running 15+15 add
    @(negedge clk);
    bus.in1  = 4'd15;
    bus.in2  = 4'd15;
    bus.mode = 4'd0;
    @(posedge clk);
    #3;
    chk("pre_reset num", bus.num, 8'h1E);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", rv);
    @(negedge clk);
    chk_all("reset_hold", rv);
    rst_n = 1'b1;
    expq.push_back(vecs[1]);

    budget = 0;
    while (expq.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("post_reset_timeout", {7'h00, (expq.size() > 0)}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 4-bit, registered arithmetic/logic unit with flags and a two-digit hex 7-segment display.
- Computes an 8-bit result `num` from `in1`/`in2` under a 4-bit `mode` select.
- Drives a 2×7-segment display of `num`.
- Standalone datapath block on the board-level demo, between switch inputs and display/LED outputs.

Parameters:
- None. Operand width is fixed at 4 bits, result at 8 bits, display at 2 digits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in1  input  4  operand A, unsigned
- in2  input  4  operand B, unsigned
- mode  input  4  operation select
- num  output  8  registered result
- neg  output  1  registered negative flag
- cero  output  1  registered zero flag
- carry  output  1  registered carry/borrow flag
- des  output  1  registered signed-overflow flag
- out  output  [1:0][6:0]  7-segment patterns; out[0] = low nibble of num, out[1] = high nibble

Behaviour:
- Reset: rst_n low asynchronously clears num, neg, cero, carry and des to 0. out therefore shows "00" (7'h40 on both digits).
- Latency: the result of inputs sampled at rising edge N is visible after edge N; latency is 1 cycle.
- out is combinational from the num register, so it adds no extra latency.
- Inputs are sampled every cycle; there is no handshake.
- mode decode (r = next num):
  - 0 ADD: r = zero-extended 5-bit in1+in2.
  - 1 SUB: r = 8-bit two's-complement in1−in2 (sign-extended).
  - 2 AND: r = {4'b0, in1&in2}.
  - 3 MUL: r = in1×in2, unsigned, 8 bits.
  - 4 OR: r = {4'b0, in1|in2}.
  - 5 XOR: r = {4'b0, in1^in2}.
  - 6 SHL: r = {4'b0,in1} << in2[2:0], 8 bits, zero fill.
  - 7 SHR: r = {4'b0,in1} >> in2[2:0].
  - 8–15: r = 0, all flags 0 except cero = 1.
- cero = (r == 0) for all modes.
- carry:
  - ADD: carry-out of the 4-bit add (r[4]).
  - SUB: borrow (in1 < in2).
  - All other modes: 0.
- neg: SUB only, = r[7]; 0 for all other modes.
- des: signed 4-bit overflow, treating in1/in2 as two's complement.
  - ADD: operands have equal sign and the 4-bit sum sign differs.
  - SUB: operand signs differ and the 4-bit difference sign differs from in1.
  - All other modes: 0.
- Mode change mid-stream takes effect on the next edge; no state is carried across operations.
- Segment encoding per digit:
  - Bit 0 = a … bit 6 = g; active-low (0 = segment lit).
  - Hex 0–F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (values in hex).

Optional Feature:
- Macro ALU_SEG_ACTIVE_HIGH_EN.
- Defined: every segment bit of out is inverted (1 = lit), for common-cathode displays. Reset shows 7'h3F per digit.
- Undefined: active-low encoding as above.
- num and all flags are identical in both builds.

Test Plan:
- rst_n low mid-operation with in1=15,in2=15,mode=0 -> immediately num=0x00, all flags 0, out[1]=out[0]=7'h40; release and one edge later num=0x1E.
- mode=0, in1=4,in2=5 -> num=0x09, carry=0, des=1, neg=0, cero=0, out[1]=7'h40, out[0]=7'h10.
- mode=0, in1=15,in2=15 -> num=0x1E, carry=1, des=0, out[1]=7'h79, out[0]=7'h06.
- mode=1, in1=0,in2=10 -> num=0xF6, neg=1, carry=1, des=0; then in1=15,in2=9 -> num=0x06, neg=0, carry=0, des=0.
- mode=2, in1=15,in2=0 -> num=0x00, cero=1; in1=12,in2=4 -> num=0x04, cero=0.
- mode=4, in1=10,in2=5 -> num=0x0F, out[0]=7'h0E; in1=0,in2=0 -> cero=1. mode=3, 15×15 -> num=0xE1, neg=0. mode=9 -> num=0, cero=1.
